// File: rtl/event_ctrl_unit.sv
// event_ctrl_unit
// Multi-channel event-control detector. Each of N single-bit channels is
// compared against its previous-cycle sample and checked for any-change,
// posedge or negedge. The check is qualified per channel by iff_i. All
// qualified hits are OR-combined into one registered event. That event is
// offered on a valid/ready handshake, together with a channel mask and two
// saturating counters.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   en_i           detector enable; low returns the unit to INIT
//   sig_i[N]       watched channels
//   iff_i[N]       per-channel qualifier
//   mode_i[2N]     per-channel mode: 00 any, 01 pos, 10 neg, 11 off
//   evt_valid_o    event pending
//   evt_ready_i    consumer accepts the pending event
//   evt_mask_o[N]  channels contributing to the pending event
//   evt_count_o    events raised since reset (saturating)
//   merge_count_o  hits merged into an already pending event (saturating)
module event_ctrl_unit #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [N-1:0]     sig_i,
   input  logic [N-1:0]     iff_i,
   input  logic [2*N-1:0]   mode_i,
   output logic             evt_valid_o,
   input  logic             evt_ready_i,
   output logic [N-1:0]     evt_mask_o,
   output logic [CNT_W-1:0] evt_count_o,
   output logic [CNT_W-1:0] merge_count_o
);

   typedef enum logic [1:0] {
      ST_INIT    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_PENDING = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Saturating increment: the counter sticks at its maximum instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t           state_q, state_d;
   logic [N-1:0]     sig_q;
   logic             valid_q, valid_d;
   logic [N-1:0]     mask_q, mask_d;
   logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
   logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;
   logic [N-1:0]     hit_s;
   logic             fire_s;

   // Per-channel hit detection against the previous sample.
   // Nothing is detected while in INIT, because INIT only captures the baseline.
   always_comb begin
      hit_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         case (mode_i[2*i +: 2])
            2'b00:   hit_s[i] = sig_q[i] ^ sig_i[i];
            2'b01:   hit_s[i] = ~sig_q[i] & sig_i[i];
            2'b10:   hit_s[i] = sig_q[i] & ~sig_i[i];
            default: hit_s[i] = 1'b0;
         endcase
      end
      if (state_q == ST_INIT) begin
         hit_s = {N{1'b0}};
      end else begin
         hit_s = hit_s & iff_i;
      end
   end

   assign fire_s = |hit_s;

   // Next-state, event-register and counter update logic.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      mask_d      = mask_q;
      evt_cnt_d   = evt_cnt_q;
      merge_cnt_d = merge_cnt_q;
      if (!en_i) begin
         state_d = ST_INIT;
         valid_d = 1'b0;
         mask_d  = {N{1'b0}};
      end else begin
         case (state_q)
            ST_INIT: begin
               state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (fire_s) begin
                  state_d   = ST_PENDING;
                  valid_d   = 1'b1;
                  mask_d    = hit_s;
                  evt_cnt_d = sat_inc(evt_cnt_q);
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_PENDING: begin
               if (evt_ready_i && fire_s) begin
                  // The pending event is consumed and a new one is raised in the
                  // same cycle, so valid stays high with no dead cycle.
                  mask_d    = hit_s;
                  evt_cnt_d = sat_inc(evt_cnt_q);
               end else if (evt_ready_i) begin
                  state_d = ST_ARMED;
                  valid_d = 1'b0;
                  mask_d  = {N{1'b0}};
               end else if (fire_s) begin
                  mask_d      = mask_q | hit_s;
                  merge_cnt_d = sat_inc(merge_cnt_q);
               end else begin
                  state_d = ST_PENDING;
               end
            end
            default: begin
               state_d = ST_INIT;
               valid_d = 1'b0;
               mask_d  = {N{1'b0}};
            end
         endcase
      end
   end

   // State, sample and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         sig_q       <= {N{1'b0}};
         valid_q     <= 1'b0;
         mask_q      <= {N{1'b0}};
         evt_cnt_q   <= {CNT_W{1'b0}};
         merge_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         sig_q       <= sig_i;
         valid_q     <= valid_d;
         mask_q      <= mask_d;
         evt_cnt_q   <= evt_cnt_d;
         merge_cnt_q <= merge_cnt_d;
      end
   end

   assign evt_valid_o   = valid_q;
   assign evt_mask_o    = mask_q;
   assign evt_count_o   = evt_cnt_q;
   assign merge_count_o = merge_cnt_q;

endmodule

// File: tb/tb_event_ctrl_unit.sv
// Directed testbench for event_ctrl_unit. Two instances share one stimulus:
// dut_a uses CNT_W=8 and dut_b uses CNT_W=2, so that counter saturation can
// be observed on dut_b.
module tb_event_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_i;
   logic [3:0] sig_i;
   logic [3:0] iff_i;
   logic [7:0] mode_i;
   logic       evt_ready_i;

   logic       valid_a, valid_b;
   logic [3:0] mask_a, mask_b;
   logic [7:0] cnt_a, merge_a;
   logic [1:0] cnt_b, merge_b;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;
   int exp_merge = 0;

   always #5 clk = ~clk;

   event_ctrl_unit #(.N(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .sig_i(sig_i), .iff_i(iff_i),
      .mode_i(mode_i), .evt_valid_o(valid_a), .evt_ready_i(evt_ready_i),
      .evt_mask_o(mask_a), .evt_count_o(cnt_a), .merge_count_o(merge_a));

   event_ctrl_unit #(.N(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .sig_i(sig_i), .iff_i(iff_i),
      .mode_i(mode_i), .evt_valid_o(valid_b), .evt_ready_i(evt_ready_i),
      .evt_mask_o(mask_b), .evt_count_o(cnt_b), .merge_count_o(merge_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en_i = 1'b0; sig_i = 4'b0000; iff_i = 4'b1111;
      mode_i = 8'hFF; evt_ready_i = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({valid_a, mask_a, cnt_a, merge_a} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_a: got v=%b m=%b c=%0d mg=%0d, want all 0", valid_a, mask_a, cnt_a, merge_a);
      end
      n_cmp++;
      if ({valid_b, mask_b, cnt_b, merge_b} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_b: got v=%b m=%b c=%0d mg=%0d, want all 0", valid_b, mask_b, cnt_b, merge_b);
      end
      rst_n = 1'b1;
      exp_cnt = 0; exp_merge = 0;
   endtask

   task automatic test_posedge();
      mode_i = 8'b11_11_01_11; en_i = 1'b1; sig_i = 4'b0000;
      tick(); tick();
      sig_i = 4'b0010;
      tick(); exp_cnt++;
      n_cmp++;
      if ({valid_a, mask_a} !== 5'b1_0010 || cnt_a !== 8'(exp_cnt)) begin
         n_err++;
         $display("FAIL posedge_evt: got v=%b m=%b c=%0d, want v=1 m=0010 c=%0d", valid_a, mask_a, cnt_a, exp_cnt);
      end
      evt_ready_i = 1'b1;
      tick();
      n_cmp++;
      if (valid_a !== 1'b0 || mask_a !== 4'b0000) begin
         n_err++;
         $display("FAIL posedge_ack: got v=%b m=%b, want v=0 m=0000", valid_a, mask_a);
      end
   endtask

   task automatic test_negedge_off();
      mode_i = 8'b11_10_11_11;
      sig_i = 4'b0110;
      tick();
      n_cmp++;
      if (valid_a !== 1'b0) begin
         n_err++;
         $display("FAIL neg_rise: got v=%b, want v=0", valid_a);
      end
      sig_i = 4'b0010;
      tick(); exp_cnt++;
      n_cmp++;
      if ({valid_a, mask_a} !== 5'b1_0100 || cnt_a !== 8'(exp_cnt)) begin
         n_err++;
         $display("FAIL neg_fall: got v=%b m=%b c=%0d, want v=1 m=0100 c=%0d", valid_a, mask_a, cnt_a, exp_cnt);
      end
      tick();
      mode_i = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         sig_i[3] = ~sig_i[3];
         tick();
         n_cmp++;
         if (valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL off_toggle%0d: got v=%b, want v=0", k, valid_a);
         end
      end
   endtask

   task automatic test_iff();
      mode_i = 8'b11_11_11_00; iff_i = 4'b1110;
      sig_i[0] = ~sig_i[0];
      tick();
      n_cmp++;
      if (valid_a !== 1'b0) begin
         n_err++;
         $display("FAIL iff_low: got v=%b, want v=0", valid_a);
      end
      iff_i = 4'b1111;
      sig_i[0] = ~sig_i[0];
      tick(); exp_cnt++;
      n_cmp++;
      if ({valid_a, mask_a} !== 5'b1_0001 || cnt_a !== 8'(exp_cnt)) begin
         n_err++;
         $display("FAIL iff_high: got v=%b m=%b c=%0d, want v=1 m=0001 c=%0d", valid_a, mask_a, cnt_a, exp_cnt);
      end
      tick();
   endtask

   task automatic test_merge();
      mode_i = 8'b11_11_00_00; evt_ready_i = 1'b0;
      sig_i[0] = ~sig_i[0];
      tick(); exp_cnt++;
      sig_i[1] = ~sig_i[1];
      tick(); exp_merge++;
      n_cmp++;
      if ({valid_a, mask_a} !== 5'b1_0011 || cnt_a !== 8'(exp_cnt) || merge_a !== 8'(exp_merge)) begin
         n_err++;
         $display("FAIL merge: got v=%b m=%b c=%0d mg=%0d, want v=1 m=0011 c=%0d mg=%0d",
                  valid_a, mask_a, cnt_a, merge_a, exp_cnt, exp_merge);
      end
      evt_ready_i = 1'b1;
      tick();
      n_cmp++;
      if (valid_a !== 1'b0 || mask_a !== 4'b0000) begin
         n_err++;
         $display("FAIL merge_ack: got v=%b m=%b, want v=0 m=0000", valid_a, mask_a);
      end
   endtask

   task automatic test_back_to_back();
      mode_i = 8'b00_11_11_00; evt_ready_i = 1'b0;
      sig_i[0] = ~sig_i[0];
      tick(); exp_cnt++;
      evt_ready_i = 1'b1;
      sig_i[3] = ~sig_i[3];
      tick(); exp_cnt++;
      n_cmp++;
      if ({valid_a, mask_a} !== 5'b1_1000 || cnt_a !== 8'(exp_cnt) || merge_a !== 8'(exp_merge)) begin
         n_err++;
         $display("FAIL b2b: got v=%b m=%b c=%0d mg=%0d, want v=1 m=1000 c=%0d mg=%0d",
                  valid_a, mask_a, cnt_a, merge_a, exp_cnt, exp_merge);
      end
      tick();
      n_cmp++;
      if (valid_a !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_ack: got v=%b, want v=0", valid_a);
      end
   endtask

   task automatic test_saturation();
      // Restart from reset so that both counters begin at zero.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      en_i = 1'b1; sig_i = 4'b0000; iff_i = 4'b1111; mode_i = 8'b11_11_11_00;
      evt_ready_i = 1'b1;
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         sig_i[0] = ~sig_i[0];
         tick();
         tick();
      end
      n_cmp++;
      if (cnt_b !== 2'd3) begin
         n_err++;
         $display("FAIL sat_b: got c=%0d, want 3", cnt_b);
      end
      n_cmp++;
      if (cnt_a !== 8'd5) begin
         n_err++;
         $display("FAIL sat_a: got c=%0d, want 5", cnt_a);
      end
   endtask

   task automatic test_en_drop();
      evt_ready_i = 1'b0;
      sig_i[0] = ~sig_i[0];
      tick();
      n_cmp++;
      if (valid_a !== 1'b1) begin
         n_err++;
         $display("FAIL en_pend: got v=%b, want v=1", valid_a);
      end
      en_i = 1'b0;
      tick();
      n_cmp++;
      if (valid_a !== 1'b0 || mask_a !== 4'b0000) begin
         n_err++;
         $display("FAIL en_drop: got v=%b m=%b, want v=0 m=0000", valid_a, mask_a);
      end
      en_i = 1'b1;
      tick(); tick(); tick();
      n_cmp++;
      if (valid_a !== 1'b0 || cnt_a !== 8'd6) begin
         n_err++;
         $display("FAIL en_rearm_quiet: got v=%b c=%0d, want v=0 c=6", valid_a, cnt_a);
      end
      // A change right after the INIT sample must still be seen.
      en_i = 1'b0; tick();
      en_i = 1'b1; tick();
      sig_i[0] = ~sig_i[0];
      tick();
      n_cmp++;
      if ({valid_a, mask_a} !== 5'b1_0001 || cnt_a !== 8'd7) begin
         n_err++;
         $display("FAIL en_first: got v=%b m=%b c=%0d, want v=1 m=0001 c=7", valid_a, mask_a, cnt_a);
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({valid_a, mask_a, cnt_a, merge_a} !== 21'd0 || {valid_b, mask_b, cnt_b, merge_b} !== 9'd0) begin
         n_err++;
         $display("FAIL async_rst: got v=%b m=%b c=%0d mg=%0d, want all 0", valid_a, mask_a, cnt_a, merge_a);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_posedge();
      test_negedge_off();
      test_iff();
      test_merge();
      test_back_to_back();
      test_saturation();
      test_en_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
